// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Definitions shared between the serial LFSR generator chain and the
// receive-side checker:
//   - chk_state_e   : checker state encoding (SEED, VERIFY, LOCK)
//   - LFSR_WIDTH/TAP: default polynomial used by both ends of the link
//   - lfsr_next_bit : XNOR feedback bit for a given tap pair and register
// Register convention: vector bit [i-1] holds stage s[i], so bit [0] is the
// newest bit and bit [width-1] is the oldest.
// ---------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } chk_state_e;

  localparam int LFSR_WIDTH = 10;
  localparam int LFSR_TAP   = 7;

  // Widest register the helper accepts; narrower registers are zero-extended.
  localparam int MAX_WIDTH  = 32;

  // tap_idx / last_idx are zero-based vector positions of s[TAP] and s[WIDTH].
  function automatic logic lfsr_next_bit(input logic [4:0]           tap_idx,
                                         input logic [4:0]           last_idx,
                                         input logic [MAX_WIDTH-1:0] s);
    return ~(s[tap_idx] ^ s[last_idx]);
  endfunction

endpackage

// File: rtl/lfsr_pred_reg.sv
// ---------------------------------------------------------------------------
// lfsr_pred_reg
// WIDTH-stage receive shift register with the XNOR next-bit prediction.
// Ports:
//   clk, reset (async, active-low)
//   en      : shift d into s[1] this cycle
//   d       : received serial bit
//   p       : predicted value of the incoming bit (from the pre-shift state)
//   s_post  : register contents after this cycle's shift (valid when en=1)
// ---------------------------------------------------------------------------
module lfsr_pred_reg
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH,
  parameter int TAP   = LFSR_TAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             d,
  output logic             p,
  output logic [WIDTH-1:0] s_post
);

  localparam logic [4:0] TAP_IDX  = 5'(TAP - 1);
  localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);

  logic [WIDTH-1:0]     s_q;
  logic [WIDTH-1:0]     s_d;
  logic [MAX_WIDTH-1:0] s_ext;

  assign s_d[0] = en ? d : s_q[0];

  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_stage
    assign s_d[gi] = en ? s_q[gi-1] : s_q[gi];
  end

  always_comb begin
    s_ext            = '0;
    s_ext[WIDTH-1:0] = s_q;
    p                = lfsr_next_bit(TAP_IDX, LAST_IDX, s_ext);
  end

  assign s_post = s_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
// Serial PRBS checker for the XNOR-feedback LFSR stream. Seeds itself from
// the received bits, qualifies GOOD_TO_LOCK consecutive predictions, then
// counts checked bits and mismatches while locked. Lock is dropped when
// LOSS_THRESH errors fall inside one WINDOW-bit window.
// Ports:
//   clk, reset (async, active-low)
//   en        : d valid this cycle; nothing advances when low (err clears)
//   d         : received serial bit
//   clr_cnt   : synchronous clear of err_count / bit_count (ignores en)
//   locked    : checker in LOCK
//   err       : one-cycle pulse per mismatched bit while locked
//   err_count : saturating mismatch count while locked
//   bit_count : saturating checked-bit count while locked
//   stuck     : pulse when a seed attempt landed on the all-ones lockup
// ---------------------------------------------------------------------------
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH        = LFSR_WIDTH,
  parameter int TAP          = LFSR_TAP,
  parameter int GOOD_TO_LOCK = 16,
  parameter int WINDOW       = 64,
  parameter int LOSS_THRESH  = 4,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          d,
  input  logic          clr_cnt,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] bit_count,
  output logic          stuck
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GOOD_TO_LOCK + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);

  localparam logic [SW-1:0] SEED_LAST = SW'(WIDTH - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_TO_LOCK - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [EW-1:0] LOSS_LVL  = EW'(LOSS_THRESH);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  logic             p;
  logic [WIDTH-1:0] s_post;
  logic             mismatch;

  lfsr_pred_reg #(
    .WIDTH (WIDTH),
    .TAP   (TAP)
  ) u_pred (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .d      (d),
    .p      (p),
    .s_post (s_post)
  );

  assign mismatch = d ^ p;

  chk_state_e    state_q,     state_d;
  logic [SW-1:0] seed_cnt_q,  seed_cnt_d;
  logic [GW-1:0] good_cnt_q,  good_cnt_d;
  logic [WW-1:0] win_cnt_q,   win_cnt_d;
  logic [EW-1:0] win_err_q,   win_err_d;
  logic [EW-1:0] win_err_inc;
  logic [CW-1:0] err_count_q, err_count_d;
  logic [CW-1:0] bit_count_q, bit_count_d;
  logic          locked_q,    locked_d;
  logic          err_q,       err_d;
  logic          stuck_q,     stuck_d;

  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    good_cnt_d  = good_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    stuck_d     = stuck_q;
    err_d       = 1'b0;
    // Window error count including the current bit, so a window-ending
    // error is seen by the loss check before the wrap clears the count.
    win_err_inc = win_err_q + (mismatch ? EW'(1) : EW'(0));

    if (en) begin
      stuck_d = 1'b0;
      unique case (state_q)
        ST_SEED: begin
          if (seed_cnt_q == SEED_LAST) begin
            seed_cnt_d = '0;
            if (&s_post) begin
              stuck_d = 1'b1;
            end else begin
              state_d    = ST_VERIFY;
              good_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + SW'(1);
          end
        end

        ST_VERIFY: begin
          if (mismatch) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
          end else if (good_cnt_q == GOOD_LAST) begin
            state_d   = ST_LOCK;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end

        ST_LOCK: begin
          if (bit_count_q != CNT_MAX) begin
            bit_count_d = bit_count_q + CW'(1);
          end
          if (mismatch) begin
            err_d = 1'b1;
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CW'(1);
            end
          end
          if (mismatch && (win_err_inc == LOSS_LVL)) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            win_err_d = win_err_inc;
          end
        end

        default: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_count_d = '0;
      bit_count_d = '0;
    end

    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SEED;
      seed_cnt_q  <= '0;
      good_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      good_cnt_q  <= good_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      stuck_q     <= stuck_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;
  assign stuck     = stuck_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
// Directed bench for lfsr_checker (WIDTH=10, TAP=7). A reference XNOR LFSR
// from a zero seed produces the stream; selected bits are inverted.
// Bit numbers below are 1-based counts of enabled bits since reset release.
// Note: the checker shifts the received bit, so a single inverted bit is
// seen three times while locked: at the bit itself and again as it passes
// stages TAP and WIDTH (bits n, n+7, n+10).
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        en      = 1'b0;
  logic        d       = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic        err;
  logic [15:0] err_count;
  logic [15:0] bit_count;
  logic        stuck;

  always #5 clk = ~clk;

  lfsr_checker #(
    .WIDTH        (10),
    .TAP          (7),
    .GOOD_TO_LOCK (16),
    .WINDOW       (64),
    .LOSS_THRESH  (4),
    .CW           (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .d         (d),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .bit_count (bit_count),
    .stuck     (stuck)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] gen;
  int nbits, ncyc;
  int first_lock, first_lock_cyc, first_loss, relock;
  int first_err, n_err, first_stuck, n_stuck;
  logic prev_locked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Assert reset between clock edges, verify outputs cleared at once,
  // then release and clear the bench statistics.
  task automatic start(input string tag, input bit reset_gen);
    @(posedge clk);
    #3;
    en      = 1'b0;
    clr_cnt = 1'b0;
    reset   = 1'b0;
    #1;
    check({tag, " rst locked"},    32'(locked),    32'd0);
    check({tag, " rst err"},       32'(err),       32'd0);
    check({tag, " rst stuck"},     32'(stuck),     32'd0);
    check({tag, " rst err_count"}, 32'(err_count), 32'd0);
    check({tag, " rst bit_count"}, 32'(bit_count), 32'd0);
    if (reset_gen) gen = '0;
    nbits = 0; ncyc = 0;
    first_lock = 0; first_lock_cyc = 0; first_loss = 0; relock = 0;
    first_err = 0; n_err = 0; first_stuck = 0; n_stuck = 0;
    prev_locked = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // One clock: optionally an enabled bit (inverted or forced to 1).
  task automatic send(input bit e, input bit inv, input bit force1, input bit clr);
    logic nb;
    if (e) begin
      nb  = ~(gen[6] ^ gen[9]);
      gen = {gen[8:0], nb};
      d   = force1 ? 1'b1 : (nb ^ inv);
      nbits++;
    end else begin
      d = 1'($urandom_range(0, 1));
    end
    en      = e;
    clr_cnt = clr;
    ncyc++;
    @(posedge clk);
    #1;
    if (locked && !prev_locked) begin
      if (first_lock == 0) begin
        first_lock     = nbits;
        first_lock_cyc = ncyc;
      end else if (relock == 0) begin
        relock = nbits;
      end
    end
    if (!locked && prev_locked && first_loss == 0) first_loss = nbits;
    prev_locked = locked;
    if (err) begin
      n_err++;
      if (first_err == 0) first_err = nbits;
    end
    if (stuck) begin
      n_stuck++;
      if (first_stuck == 0) first_stuck = nbits;
    end
  endtask

  initial begin
    // 1: clean stream, 1000 bits.
    start("t1", 1'b1);
    for (int i = 1; i <= 1000; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1 lock bit",  32'(first_lock), 32'd26);
    check("t1 locked",    32'(locked),     32'd1);
    check("t1 err_count", 32'(err_count),  32'd0);
    check("t1 bit_count", 32'(bit_count),  32'd974);
    check("t1 err pulses", 32'(n_err),     32'd0);
    $display("[t1] clean stream: lock at bit %0d, bits=%0d errs=%0d", first_lock, bit_count, err_count);

    // 2: bit 500 inverted -> errors at 500, 507, 510 (same window, no loss).
    start("t2", 1'b1);
    for (int i = 1; i <= 1000; i++) send(1'b1, (i == 500), 1'b0, 1'b0);
    check("t2 first err",  32'(first_err), 32'd500);
    check("t2 err pulses", 32'(n_err),     32'd3);
    check("t2 err_count",  32'(err_count), 32'd3);
    check("t2 locked",     32'(locked),    32'd1);
    check("t2 loss",       32'(first_loss), 32'd0);
    check("t2 bit_count",  32'(bit_count), 32'd974);
    $display("[t2] single flip at 500: err pulses=%0d first at %0d count=%0d", n_err, first_err, err_count);

    // 3: bits 535..538 inverted; 538 is the last bit of the window 475..538,
    // so the 4th error must still force loss there.
    start("t3", 1'b1);
    for (int i = 1; i <= 600; i++) send(1'b1, (i >= 535 && i <= 538), 1'b0, 1'b0);
    check("t3 lock bit",   32'(first_lock), 32'd26);
    check("t3 loss bit",   32'(first_loss), 32'd538);
    check("t3 relock bit", 32'(relock),     32'd564);
    check("t3 err_count",  32'(err_count),  32'd4);
    check("t3 bit_count",  32'(bit_count),  32'd548);
    check("t3 err pulses", 32'(n_err),      32'd4);
    $display("[t3] burst of 4: loss at %0d relock at %0d errs=%0d", first_loss, relock, err_count);

    // 4: d stuck at 1 -> seed rejected every 10 bits.
    start("t4", 1'b1);
    for (int i = 1; i <= 40; i++) send(1'b1, 1'b0, 1'b1, 1'b0);
    check("t4 first stuck", 32'(first_stuck), 32'd10);
    check("t4 stuck pulses", 32'(n_stuck),    32'd4);
    check("t4 never locked", 32'(first_lock), 32'd0);
    check("t4 err_count",    32'(err_count),  32'd0);
    $display("[t4] all-ones input: stuck pulses=%0d", n_stuck);

    // 5: en alternates 1/0; enabled bit k lands on cycle 2k-1.
    start("t5", 1'b1);
    for (int i = 1; i <= 100; i++) send((i % 2) == 1, 1'b0, 1'b0, 1'b0);
    check("t5 lock bit",   32'(first_lock),     32'd26);
    check("t5 lock cycle", 32'(first_lock_cyc), 32'd51);
    check("t5 bit_count",  32'(bit_count),      32'd24);
    check("t5 err pulses", 32'(n_err),          32'd0);
    $display("[t5] en toggling: lock at bit %0d cycle %0d bits=%0d", first_lock, first_lock_cyc, bit_count);

    // 6: clear collides with an error, then mid-stream reset and re-acquire.
    start("t6", 1'b1);
    for (int i = 1; i <= 249; i++) send(1'b1, (i == 200), 1'b0, 1'b0);
    check("t6 err_count pre", 32'(err_count), 32'd3);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    check("t6 clr err_count", 32'(err_count), 32'd0);
    check("t6 clr bit_count", 32'(bit_count), 32'd0);
    check("t6 clr err pulse", 32'(err),       32'd1);
    for (int i = 1; i <= 3; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6 bit_count post", 32'(bit_count), 32'd3);
    check("t6 locked pre rst", 32'(locked),    32'd1);
    start("t6b", 1'b0);
    for (int i = 1; i <= 40; i++) send(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6 relock bit",  32'(first_lock), 32'd26);
    check("t6 err_count",   32'(err_count),  32'd0);
    check("t6 bit_count",   32'(bit_count),  32'd14);
    $display("[t6] clear+reset: relock at bit %0d bits=%0d", first_lock, bit_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
